// File: rtl/alarm_controller.sv
// Alarm sequencer: stores the alarm time, detects the alarm edge and walks ring/snooze/timeout phases.
// Optional build macro ALARM_BEEP_PATTERN_EN gates the buzzer with a 1 s on / 1 s off phase while ringing.
module alarm_controller #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3,
    parameter int RST_HOUR       = 7,
    parameter int RST_MIN        = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       key_set_pulse,
    input  logic       key_inc_pulse,
    input  logic       key_stop_pulse,
    input  logic [4:0] hour_in,
    input  logic [5:0] min_in,
    input  logic [5:0] sec_in,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       alarm_armed,
    output logic       buzzer_en,
    output logic       show_alarm,
    output logic [1:0] set_field
);

    localparam logic [7:0] RING_LAST   = 8'(RING_SECONDS - 1);
    localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SECONDS - 1);
    localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);
    localparam logic [4:0] HOUR_RST    = 5'(RST_HOUR);
    localparam logic [5:0] MIN_RST     = 6'(RST_MIN);

    typedef enum logic [2:0] {
        S_DISARMED,
        S_SET_HOUR,
        S_SET_MIN,
        S_ARMED,
        S_RINGING,
        S_SNOOZE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] ring_cnt;
    logic [9:0] snooze_cnt;
    logic [2:0] snooze_used;
    logic       match, match_d, trigger;
    logic       ring_done, snooze_done, snooze_ok;
`ifdef ALARM_BEEP_PATTERN_EN
    logic       beep_phase;
`endif

    // Edge detect so a held match (or arming while matched) cannot retrigger.
    assign match       = (hour_in == alarm_hour) && (min_in == alarm_min) && (sec_in == 6'd0);
    assign trigger     = match && !match_d;
    assign ring_done   = tick_1hz && (ring_cnt == RING_LAST);
    assign snooze_done = tick_1hz && (snooze_cnt == SNOOZE_LAST);
    assign snooze_ok   = snooze_used < SNOOZE_MAX;

    always_ff @(posedge clk) begin
        if (rst) state <= S_DISARMED;
        else     state <= state_nxt;
    end

    // Keys with an effect are checked first so they always outrank trigger and timeouts.
    always_comb begin
        state_nxt = state;
        case (state)
            S_DISARMED: begin
                if (key_stop_pulse)     state_nxt = S_ARMED;
                else if (key_set_pulse) state_nxt = S_SET_HOUR;
            end
            S_SET_HOUR: begin
                if (key_stop_pulse)     state_nxt = S_DISARMED;
                else if (key_set_pulse) state_nxt = S_SET_MIN;
            end
            S_SET_MIN: begin
                if (key_stop_pulse)     state_nxt = S_DISARMED;
                else if (key_set_pulse) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (key_stop_pulse)     state_nxt = S_DISARMED;
                else if (key_set_pulse) state_nxt = S_SET_HOUR;
                else if (trigger)       state_nxt = S_RINGING;
            end
            S_RINGING: begin
                if (key_stop_pulse)                  state_nxt = S_ARMED;
                else if (key_inc_pulse && snooze_ok) state_nxt = S_SNOOZE;
                else if (ring_done)                  state_nxt = S_ARMED;
            end
            S_SNOOZE: begin
                if (key_stop_pulse)   state_nxt = S_ARMED;
                else if (snooze_done) state_nxt = S_RINGING;
            end
            default: state_nxt = S_DISARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_hour  <= HOUR_RST;
            alarm_min   <= MIN_RST;
            match_d     <= 1'b0;
            ring_cnt    <= 8'd0;
            snooze_cnt  <= 10'd0;
            snooze_used <= 3'd0;
`ifdef ALARM_BEEP_PATTERN_EN
            beep_phase  <= 1'b0;
`endif
        end else begin
            match_d <= match;
            if (state == S_SET_HOUR && !key_stop_pulse && !key_set_pulse && key_inc_pulse)
                alarm_hour <= (alarm_hour == 5'd23) ? 5'd0 : alarm_hour + 5'd1;
            if (state == S_SET_MIN && !key_stop_pulse && !key_set_pulse && key_inc_pulse)
                alarm_min <= (alarm_min == 6'd59) ? 6'd0 : alarm_min + 6'd1;

            if (state != S_RINGING && state_nxt == S_RINGING) begin
                ring_cnt <= 8'd0;
`ifdef ALARM_BEEP_PATTERN_EN
                beep_phase <= 1'b1;
`endif
            end else if (state == S_RINGING && tick_1hz) begin
                ring_cnt <= ring_cnt + 8'd1;
`ifdef ALARM_BEEP_PATTERN_EN
                beep_phase <= ~beep_phase;
`endif
            end

            // Snooze budget is refreshed only by a fresh alarm event, not by snooze re-rings.
            if (state == S_ARMED && state_nxt == S_RINGING)
                snooze_used <= 3'd0;
            if (state == S_RINGING && state_nxt == S_SNOOZE) begin
                snooze_cnt  <= 10'd0;
                snooze_used <= snooze_used + 3'd1;
            end else if (state == S_SNOOZE && tick_1hz) begin
                snooze_cnt <= snooze_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        alarm_armed = 1'b0;
        buzzer_en   = 1'b0;
        show_alarm  = 1'b0;
        set_field   = 2'd0;
        case (state)
            S_SET_HOUR: begin
                show_alarm = 1'b1;
                set_field  = 2'd1;
            end
            S_SET_MIN: begin
                show_alarm = 1'b1;
                set_field  = 2'd2;
            end
            S_ARMED: alarm_armed = 1'b1;
            S_RINGING: begin
                alarm_armed = 1'b1;
`ifdef ALARM_BEEP_PATTERN_EN
                buzzer_en   = beep_phase;
`else
                buzzer_en   = 1'b1;
`endif
            end
            S_SNOOZE: alarm_armed = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios plus random keys/time jumps, scored cycle by cycle
// against a countdown-based reference model through an expected-output queue.
module tb_alarm_controller;

    localparam int RS = 60;
    localparam int SS = 300;
    localparam int MS = 3;
    localparam int RH = 7;
    localparam int RM = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       key_set_pulse = 1'b0;
    logic       key_inc_pulse = 1'b0;
    logic       key_stop_pulse = 1'b0;
    logic [4:0] hour_in = 5'd0;
    logic [5:0] min_in = 6'd0;
    logic [5:0] sec_in = 6'd1;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_armed;
    logic       buzzer_en;
    logic       show_alarm;
    logic [1:0] set_field;

    alarm_controller #(
        .RING_SECONDS(RS), .SNOOZE_SECONDS(SS), .MAX_SNOOZE(MS), .RST_HOUR(RH), .RST_MIN(RM)
    ) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .key_set_pulse(key_set_pulse), .key_inc_pulse(key_inc_pulse), .key_stop_pulse(key_stop_pulse),
        .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_armed(alarm_armed),
        .buzzer_en(buzzer_en), .show_alarm(show_alarm), .set_field(set_field)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic       armed;
        logic       buz;
        logic       show;
        logic [1:0] fld;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: mode name, alarm time, and seconds/snoozes remaining.
    string m_mode = "DIS";
    int    m_hour = RH;
    int    m_min = RM;
    bit    m_prev = 1'b0;
    bit    m_beep = 1'b0;
    int    ring_left = 0;
    int    snz_left = 0;
    int    snoozes_left = 0;
    int    th = 0, tm = 0, ts = 1;

    function automatic void enter_ring();
        m_mode    = "RING";
        ring_left = RS;
        m_beep    = 1'b1;
    endfunction

    function automatic void model_step();
        bit mt, trig;
        if (rst) begin
            m_mode = "DIS"; m_hour = RH; m_min = RM; m_prev = 1'b0;
        end else begin
            mt = (int'(hour_in) == m_hour) && (int'(min_in) == m_min) && (sec_in == 6'd0);
            trig = mt && !m_prev;
            m_prev = mt;
            if (m_mode == "DIS") begin
                if (key_stop_pulse) m_mode = "ARM";
                else if (key_set_pulse) m_mode = "SH";
            end else if (m_mode == "SH") begin
                if (key_stop_pulse) m_mode = "DIS";
                else if (key_set_pulse) m_mode = "SM";
                else if (key_inc_pulse) m_hour = (m_hour + 1) % 24;
            end else if (m_mode == "SM") begin
                if (key_stop_pulse) m_mode = "DIS";
                else if (key_set_pulse) m_mode = "ARM";
                else if (key_inc_pulse) m_min = (m_min + 1) % 60;
            end else if (m_mode == "ARM") begin
                if (key_stop_pulse) m_mode = "DIS";
                else if (key_set_pulse) m_mode = "SH";
                else if (trig) begin
                    snoozes_left = MS;
                    enter_ring();
                end
            end else if (m_mode == "RING") begin
                if (key_stop_pulse) m_mode = "ARM";
                else if (key_inc_pulse && snoozes_left > 0) begin
                    snoozes_left--;
                    snz_left = SS;
                    m_mode = "SNZ";
                end else if (tick_1hz) begin
                    ring_left--;
                    m_beep = !m_beep;
                    if (ring_left == 0) m_mode = "ARM";
                end
            end else if (m_mode == "SNZ") begin
                if (key_stop_pulse) m_mode = "ARM";
                else if (tick_1hz) begin
                    snz_left--;
                    if (snz_left == 0) enter_ring();
                end
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.h     = 5'(m_hour);
        e.m     = 6'(m_min);
        e.armed = (m_mode == "ARM") || (m_mode == "RING") || (m_mode == "SNZ");
`ifdef ALARM_BEEP_PATTERN_EN
        e.buz   = (m_mode == "RING") && m_beep;
`else
        e.buz   = (m_mode == "RING");
`endif
        e.show  = (m_mode == "SH") || (m_mode == "SM");
        e.fld   = (m_mode == "SH") ? 2'd1 : (m_mode == "SM") ? 2'd2 : 2'd0;
        return e;
    endfunction

    // Monitor: every registered cycle the DUT presents one output word to score.
    always @(posedge clk) begin
        exp_t e, a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{alarm_hour, alarm_min, alarm_armed, buzzer_en, show_alarm, set_field};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle t=%0t got h=%0d m=%0d armed=%0b buz=%0b show=%0b fld=%0d want h=%0d m=%0d armed=%0b buz=%0b show=%0b fld=%0d",
                         $time, a.h, a.m, a.armed, a.buz, a.show, a.fld, e.h, e.m, e.armed, e.buz, e.show, e.fld);
            end
        end
    end

    task automatic step(input bit r, input bit s, input bit i, input bit p, input bit t);
        @(negedge clk);
        rst = r; key_set_pulse = s; key_inc_pulse = i; key_stop_pulse = p; tick_1hz = t;
        hour_in = 5'(th); min_in = 6'(tm); sec_in = 6'(ts);
        model_step();
        exp_q.push_back(model_out());
    endtask

    task automatic key(input bit s, input bit i, input bit p);
        step(1'b0, s, i, p, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic adv();
        ts++;
        if (ts == 60) begin ts = 0; tm++; end
        if (tm == 60) begin tm = 0; th++; end
        if (th == 24) th = 0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        th = h; tm = m; ts = s;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            adv();
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            idle();
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic ring_at_0630();
        set_time(6, 29, 59); idle();
        set_time(6, 30, 0);  idle();
    endtask

    initial begin
        int r, q;
        bit t, s, i, p;

        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        settle();
        chk("rst_hour", alarm_hour, 7);
        chk("rst_min", alarm_min, 0);
        chk("rst_buzzer", buzzer_en, 0);
        chk("rst_armed", alarm_armed, 0);
        chk("rst_show", show_alarm, 0);
        chk("rst_field", set_field, 0);

        key(1, 0, 0);
        settle();
        chk("sethour_show", show_alarm, 1);
        chk("sethour_field", set_field, 1);
        repeat (17) key(0, 1, 0);
        key(1, 0, 0);
        settle();
        chk("setmin_field", set_field, 2);
        repeat (30) key(0, 1, 0);
        key(1, 0, 0);
        settle();
        chk("hour_wrap", alarm_hour, 0);
        chk("min_set", alarm_min, 30);
        chk("armed_after_set", alarm_armed, 1);
        chk("show_after_set", show_alarm, 0);

        key(1, 0, 0);
        repeat (6) key(0, 1, 0);
        key(1, 0, 0);
        key(1, 0, 0);
        ring_at_0630();
        settle();
        chk("ring_start", buzzer_en, 1);
        ticks(RS - 1);
        settle();
        chk("ring_before_timeout", alarm_armed, 1);
        ticks(1);
        settle();
        chk("timeout_buzzer", buzzer_en, 0);
        chk("timeout_armed", alarm_armed, 1);

        ring_at_0630();
        for (int n = 0; n < MS; n++) begin
            key(0, 1, 0);
            settle();
            chk("snooze_quiet", buzzer_en, 0);
            ticks(SS);
            settle();
            chk("snooze_rering", buzzer_en, 1);
        end
        key(0, 1, 0);
        settle();
        chk("snooze_exhausted", buzzer_en, 1);
        key(0, 0, 1);
        settle();
        chk("stop_buzzer", buzzer_en, 0);
        chk("stop_armed", alarm_armed, 1);

        ring_at_0630();
        key(0, 1, 1);
        settle();
        chk("stop_inc_buzzer", buzzer_en, 0);
        chk("stop_inc_armed", alarm_armed, 1);
        ticks(3);

        ring_at_0630();
        key(0, 1, 0);
        ticks(5);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("rst_snooze_armed", alarm_armed, 0);
        chk("rst_snooze_hour", alarm_hour, 7);
        chk("rst_snooze_min", alarm_min, 0);
        set_time(6, 59, 59); idle();
        set_time(7, 0, 0);   idle();
        settle();
        chk("disarmed_no_buzz", buzzer_en, 0);

        key(0, 0, 1);
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 199);
            if (r == 0) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            else if (r < 3) key(1, 0, 0);
            else if (r < 9) key(0, 1, 0);
            else if (r < 11) key(0, 0, 1);
            else if (r < 13) begin
                s = 1'($urandom_range(0, 1)); i = 1'($urandom_range(0, 1)); p = 1'($urandom_range(0, 1));
                key(s, i, p);
            end else begin
                q = $urandom_range(0, 19);
                t = 1'($urandom_range(0, 1));
                if (q == 0) set_time(m_hour, m_min, 0);
                else if (q == 1) set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
                else if (q == 2) set_time(m_hour, m_min, 59);
                else if (t) adv();
                step(1'b0, 1'b0, 1'b0, 1'b0, t);
            end
        end

        idle();
        idle();
        settle();
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
Alarm sequencer for the digital clock. It holds a user-set alarm time and compares it against the live hour/min/sec from the time counter. It drives the buzzer through ring, snooze and auto-timeout phases. It reuses the debounced key pulses, and exports alarm fields plus a display-select flag so the scanner can show the alarm time while it is being set.

Parameters:
RING_SECONDS, 60, ticks the buzzer rings before auto-dismiss (1..255)
SNOOZE_SECONDS, 300, ticks spent in snooze before re-ringing (1..1023)
MAX_SNOOZE, 3, snoozes allowed per alarm event (0..7)
RST_HOUR, 7, alarm hour after reset (0..23)
RST_MIN, 0, alarm minute after reset (0..59)

Ports:
clk  input  1  50MHz system clock; single clock domain
rst  input  1  synchronous, active-high reset
tick_1hz  input  1  one-clk-wide pulse once per second, clk domain
key_set_pulse  input  1  debounced pulse: enter/advance alarm setting
key_inc_pulse  input  1  debounced pulse: increment field / snooze
key_stop_pulse  input  1  debounced pulse: arm/disarm / dismiss
hour_in  input  5  current hour 0..23
min_in  input  6  current minute 0..59
sec_in  input  6  current second 0..59
alarm_hour  output  5  stored alarm hour
alarm_min  output  6  stored alarm minute
alarm_armed  output  1  high in ARMED, RINGING, SNOOZE
buzzer_en  output  1  buzzer drive
show_alarm  output  1  high in SET_HOUR/SET_MIN (scanner shows alarm_hour:alarm_min:00)
set_field  output  2  0 none, 1 hour, 2 minute

Behaviour:
- All outputs and state are registered. Reset values: state=DISARMED, alarm_hour=RST_HOUR, alarm_min=RST_MIN, all other outputs 0, counters 0, match_d=0.
- match = (hour_in==alarm_hour)&&(min_in==alarm_min)&&(sec_in==0). match_d holds the previous-cycle value of match. Trigger = match & ~match_d, a rising edge only.
- Key priority within one cycle: stop > set > inc. Any key pulse outranks trigger, ring timeout and snooze timeout in the same cycle. At most one transition per cycle.
- DISARMED: set -> SET_HOUR. stop -> ARMED. Trigger is ignored.
- SET_HOUR: inc -> alarm_hour+1, wrapping 23->0. set -> SET_MIN. stop -> DISARMED, field values kept.
- SET_MIN: inc -> alarm_min+1, wrapping 59->0. set -> ARMED. stop -> DISARMED.
- ARMED: trigger -> RINGING, ring_cnt=0, snooze_used=0. stop -> DISARMED. set -> SET_HOUR.
  - If match is already high on entry, no trigger occurs until match next rises. Next rise is the next day.
- RINGING: buzzer_en=1. ring_cnt increments on tick_1hz. When ring_cnt reaches RING_SECONDS-1 and a tick arrives -> ARMED (auto-dismiss).
  - stop -> ARMED.
  - inc with snooze_used<MAX_SNOOZE -> SNOOZE: snooze_cnt=0, snooze_used+1.
  - inc with snooze_used==MAX_SNOOZE: ignored, keeps ringing.
  - set: ignored.
- SNOOZE: buzzer_en=0. snooze_cnt increments on tick_1hz. When snooze_cnt reaches SNOOZE_SECONDS-1 and a tick arrives -> RINGING with ring_cnt=0.
  - stop -> ARMED (cancel).
  - set, inc: ignored.
- Latency: buzzer_en rises 1 clk after the cycle match first goes high. Key effects appear on outputs 1 clk after the pulse.
- show_alarm=1 and set_field=1/2 in SET_HOUR/SET_MIN. Otherwise both are 0.
- Reset asserted mid-ring or mid-snooze returns to DISARMED with buzzer_en=0 on the next edge. The alarm time also reverts to RST_HOUR/RST_MIN.
- Time jumps from the clock-set controller are legal. A jump landing exactly on alarm:00 triggers, because it creates a rising edge on match.

Optional Feature:
ALARM_BEEP_PATTERN_EN
- Defined: in RINGING, buzzer_en equals a phase bit. The phase bit resets to 1 on RINGING entry and toggles on each tick_1hz, giving 1 s on / 1 s off.
- Undefined: buzzer_en is steady 1 throughout RINGING.
- State transitions are identical in both builds.

Test Plan:
- Reset -> alarm 07:00, buzzer_en=0, alarm_armed=0, show_alarm=0, set_field=0.
- set, inc x17, set, inc x30, set -> alarm_hour=0 (7+17 wraps 23->0), alarm_min=30, state ARMED, alarm_armed=1.
- Armed at 06:30, drive time 06:29:59 then 06:30:00 -> buzzer_en=1 one clk later. After 60 ticks with no keys -> buzzer_en=0, alarm_armed=1.
- Ringing, inc -> buzzer_en=0. After 300 ticks, ringing again. Repeat twice more; 4th inc ignored, buzzer stays on. stop -> ARMED.
- Ringing, stop and inc in the same clk -> ARMED, no snooze taken, buzzer_en=0.
- rst pulse during SNOOZE -> DISARMED, alarm 07:00. Setting time to 07:00:00 afterwards -> no buzzer.
